regfile_wb_queue: RTL and testbench

//  Write-back initiator for the register file write port (wen/waddr/wdata).

---
 rtl/regfile_wb_queue_if.sv | 39 +++
 rtl/regfile_wb_queue.sv | 96 +++++++++
 tb/tb_regfile_wb_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's push, drain, hazard-query and status signals.
// Valid/ready handshakes: a push transfers on a posedge where valid and ready are both high,
// and ready is never a function of its own valid.
interface regfile_wb_queue_if #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 16
);
  logic             flush;
  logic             mem_valid;
  logic             mem_ready;
  logic [ASIZE-1:0] mem_waddr;
  logic [DSIZE-1:0] mem_wdata;
  logic             alu_valid;
  logic             alu_ready;
  logic [ASIZE-1:0] alu_waddr;
  logic [DSIZE-1:0] alu_wdata;
  logic             wb_stall;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic [ASIZE-1:0] q_addr1;
  logic [ASIZE-1:0] q_addr2;
  logic             q_pend1;
  logic             q_pend2;
  logic             empty;
  logic             full;

  modport master (
    output flush, mem_valid, mem_waddr, mem_wdata, alu_valid, alu_waddr, alu_wdata,
           wb_stall, q_addr1, q_addr2,
    input  mem_ready, alu_ready, wen, waddr, wdata, q_pend1, q_pend2, empty, full
  );

  modport slave (
    input  flush, mem_valid, mem_waddr, mem_wdata, alu_valid, alu_waddr, alu_wdata,
           wb_stall, q_addr1, q_addr2,
    output mem_ready, alu_ready, wen, waddr, wdata, q_pend1, q_pend2, empty, full
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO feeding the register file write port, accepting up to two
// results per cycle (mem first, then ALU) and reporting per-address pending writes.
module regfile_wb_queue #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 16,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ASIZE-1:0] addr_mem [DEPTH];
  logic [DSIZE-1:0] data_mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic [CW-1:0] space;
  logic          empty;
  logic          wen;
  logic          mem_ready;
  logic          alu_ready;
  logic          mem_fire;
  logic          alu_fire;
  logic          pend1;
  logic          pend2;
  logic [PW-1:0] offset;
  logic          live;

  // Space comes from registered count only, so a same-cycle drain never raises ready.
  assign space     = DEPTH_C - count;
  assign empty     = (count == '0);
  assign mem_ready = (space != '0);
  assign alu_ready = bus.mem_valid ? (space >= CW'(2)) : (space != '0);
  assign mem_fire  = bus.mem_valid & mem_ready;
  assign alu_fire  = bus.alu_valid & alu_ready;
  assign wen       = !empty & !bus.wb_stall;

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.wen       = wen;
  assign bus.waddr     = empty ? '0 : addr_mem[rd_ptr];
  assign bus.wdata     = empty ? '0 : data_mem[rd_ptr];
  assign bus.empty     = empty;
  assign bus.full      = (count == DEPTH_C);
  assign bus.q_pend1   = pend1;
  assign bus.q_pend2   = pend2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(wen);
      wr_ptr <= wr_ptr + PW'(mem_fire) + PW'(alu_fire);
      count  <= count + CW'(mem_fire) + CW'(alu_fire) - CW'(wen);
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (mem_fire) begin
        addr_mem[wr_ptr] <= bus.mem_waddr;
        data_mem[wr_ptr] <= bus.mem_wdata;
      end
      if (alu_fire) begin
        addr_mem[wr_ptr + PW'(mem_fire)] <= bus.alu_waddr;
        data_mem[wr_ptr + PW'(mem_fire)] <= bus.alu_wdata;
      end
    end
  end

  // The head being written this cycle is excluded: the register file forwards it.
  always_comb begin
    pend1  = 1'b0;
    pend2  = 1'b0;
    offset = '0;
    live   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      live   = (CW'(offset) < count) && !(wen && (offset == '0));
      if (live && (addr_mem[i] == bus.q_addr1)) pend1 = 1'b1;
      if (live && (addr_mem[i] == bus.q_addr2)) pend2 = 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and randomized checks of regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int ASIZE = 4;
  localparam int DSIZE = 16;
  localparam int DEPTH = 4;
  localparam int W = ASIZE + DSIZE;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_wb_queue_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  regfile_wb_queue #(.ASIZE(ASIZE), .DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued {addr, data} entries, oldest first.
  logic [W-1:0]     exp_q[$];
  logic             exp_mem_ready, exp_alu_ready, exp_wen;
  logic [DSIZE-1:0] dut_rf [16];
  logic             seen_dead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict all outputs from the model queue and compare; record DUT writes.
  task automatic settle();
    int n;
    logic [W-1:0] head;
    logic p1, p2;
    @(negedge clk);
    n = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    exp_mem_ready = (DEPTH - n) >= 1;
    exp_alu_ready = (DEPTH - n) >= (1 + (bus.mem_valid ? 1 : 0));
    exp_wen = (n > 0) && !bus.wb_stall;
    p1 = 1'b0;
    p2 = 1'b0;
    for (int k = (exp_wen ? 1 : 0); k < n; k++) begin
      if (exp_q[k][W-1:DSIZE] == bus.q_addr1) p1 = 1'b1;
      if (exp_q[k][W-1:DSIZE] == bus.q_addr2) p2 = 1'b1;
    end
    chk("empty", bus.empty, n == 0);
    chk("full", bus.full, n == DEPTH);
    chk("mem_ready", bus.mem_ready, exp_mem_ready);
    chk("alu_ready", bus.alu_ready, exp_alu_ready);
    chk("wen", bus.wen, exp_wen);
    chk("waddr", bus.waddr, head[W-1:DSIZE]);
    chk("wdata", bus.wdata, head[DSIZE-1:0]);
    chk("q_pend1", bus.q_pend1, p1);
    chk("q_pend2", bus.q_pend2, p2);
    if (bus.wen) begin
      dut_rf[bus.waddr] = bus.wdata;
      if (bus.wdata == 16'hDEAD) seen_dead = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (bus.flush) exp_q.delete();
    else begin
      if (exp_wen) void'(exp_q.pop_front());
      if (bus.mem_valid && exp_mem_ready) exp_q.push_back({bus.mem_waddr, bus.mem_wdata});
      if (bus.alu_valid && exp_alu_ready) exp_q.push_back({bus.alu_waddr, bus.alu_wdata});
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle();
    bus.flush = 0; bus.mem_valid = 0; bus.alu_valid = 0; bus.wb_stall = 0;
    bus.mem_waddr = 0; bus.mem_wdata = 0; bus.alu_waddr = 0; bus.alu_wdata = 0;
    bus.q_addr1 = 0; bus.q_addr2 = 0;
  endtask

  task automatic push_alu(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
    bus.alu_valid = 1; bus.alu_waddr = a; bus.alu_wdata = d;
  endtask

  task automatic push_mem(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
    bus.mem_valid = 1; bus.mem_waddr = a; bus.mem_wdata = d;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    seen_dead = 1'b0;
    for (int i = 0; i < 16; i++) dut_rf[i] = '0;
    idle();
    rst = 1'b1;
    #12;
    chk("reset_wen", bus.wen, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_full", bus.full, 0);
    chk("reset_waddr", bus.waddr, 0);
    chk("reset_wdata", bus.wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ALU push: written the following cycle.
    push_alu(4'd5, 16'h1234);
    cycle();
    idle();
    settle();
    chk("single_wen", bus.wen, 1);
    chk("single_waddr", bus.waddr, 5);
    chk("single_wdata", bus.wdata, 16'h1234);
    advance();
    settle();
    chk("single_empty_after", bus.empty, 1);
    advance();

    // Dual push to r2: mem first, ALU wins.
    push_mem(4'd2, 16'h0f8c);
    push_alu(4'd2, 16'hBEEF);
    cycle();
    idle();
    settle();
    chk("dual_first", bus.wdata, 16'h0f8c);
    advance();
    settle();
    chk("dual_second", bus.wdata, 16'hBEEF);
    advance();
    cycle();
    chk("dual_last_r2", dut_rf[2], 16'hBEEF);

    // Fill under stall; read pointer starts at 3 so the drain wraps.
    bus.wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      push_alu(ASIZE'(10 + i), DSIZE'(16'hA000 + i));
      cycle();
    end
    push_mem(4'd13, 16'hA003);
    push_alu(4'd14, 16'hFFFF);
    settle();
    chk("cnt3_mem_ready", bus.mem_ready, 1);
    chk("cnt3_alu_ready", bus.alu_ready, 0);
    advance();
    bus.alu_valid = 0;
    push_mem(4'd15, 16'hFFFF);
    settle();
    chk("full_flag", bus.full, 1);
    chk("full_mem_ready", bus.mem_ready, 0);
    chk("full_alu_ready", bus.alu_ready, 0);
    advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_wen", bus.wen, 1);
      chk("drain_waddr", bus.waddr, 10 + i);
      chk("drain_wdata", bus.wdata, 16'hA000 + i);
      advance();
    end
    cycle();

    // Hazard query with r7 at head and r8 behind it.
    push_mem(4'd7, 16'h0007);
    push_alu(4'd8, 16'h0008);
    bus.wb_stall = 1;
    cycle();
    idle();
    bus.wb_stall = 1;
    bus.q_addr1 = 7; bus.q_addr2 = 8;
    settle();
    chk("haz_stall_pend1", bus.q_pend1, 1);
    advance();
    bus.wb_stall = 0;
    settle();
    chk("haz_head_pend1", bus.q_pend1, 0);
    chk("haz_next_pend2", bus.q_pend2, 1);
    advance();
    idle();
    cycle();
    cycle();

    // Asynchronous reset with three entries queued.
    bus.wb_stall = 1;
    push_mem(4'd1, 16'h1111);
    push_alu(4'd3, 16'h3333);
    cycle();
    bus.mem_valid = 0;
    push_alu(4'd4, 16'h4444);
    cycle();
    idle();
    rst = 1'b1;
    #1;
    chk("async_rst_wen", bus.wen, 0);
    chk("async_rst_empty", bus.empty, 1);
    chk("async_rst_full", bus.full, 0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle();

    // Flush with three queued plus a push in the flush cycle.
    bus.wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      push_alu(ASIZE'(i + 1), DSIZE'(16'hC000 + i));
      cycle();
    end
    idle();
    bus.flush = 1;
    push_alu(4'd9, 16'hDEAD);
    settle();
    chk("flush_head_wen", bus.wen, 1);
    chk("flush_head_data", bus.wdata, 16'hC000);
    advance();
    idle();
    settle();
    chk("flush_empty", bus.empty, 1);
    chk("flush_wen", bus.wen, 0);
    advance();
    for (int i = 0; i < 3; i++) cycle();
    chk("flush_push_dropped", seen_dead, 0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.wb_stall  = ($urandom_range(0, 3) == 0);
      bus.mem_valid = ($urandom_range(0, 1) == 1);
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.mem_waddr = ASIZE'($urandom_range(0, 15));
      bus.alu_waddr = ASIZE'($urandom_range(0, 15));
      bus.mem_wdata = DSIZE'($urandom);
      bus.alu_wdata = DSIZE'($urandom);
      bus.q_addr1   = ASIZE'($urandom_range(0, 15));
      bus.q_addr2   = ASIZE'($urandom_range(0, 15));
      if (bus.mem_wdata == 16'hDEAD) bus.mem_wdata = 16'h0;
      if (bus.alu_wdata == 16'hDEAD) bus.alu_wdata = 16'h0;
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    chk("final_empty", bus.empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
